// File: rtl/div_mant_seq.sv
// Sequential restoring divider: one quotient bit per clock. Mantissa mode divides
// {1,f1}/{1,f2} scaled by 2^(QB-1); integer mode divides f1/f2 with divide-by-zero flag.
module div_mant_seq #(
    parameter int unsigned FW = 10,
    parameter int unsigned QB = FW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    input  logic [FW-1:0] f1,
    input  logic [FW-1:0] f2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QB-1:0] q,
    output logic [FW:0]   rem,
    output logic          sticky,
    output logic          dz
);

    localparam int unsigned RW = FW + 1;
    localparam int unsigned CW = $clog2(QB + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [RW-1:0] div_q, div_d;
    logic [RW-1:0] r_q, r_d;
    logic [QB-1:0] dvd_q, dvd_d;
    logic [QB-1:0] quo_q, quo_d;
    logic [CW-1:0] count_q, count_d;
    logic [QB-1:0] q_q, q_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          sticky_q, sticky_d;
    logic          dz_q, dz_d;

    // Trial subtraction of one step; the extra top bit of diff is the borrow.
    logic [RW:0]   sh;
    logic [RW+1:0] diff;
    logic          borrow;
    logic [RW-1:0] r_nx;
    logic [QB-1:0] quo_nx;
    logic          last_iter;
    logic [QB+FW-1:0] int_dvd;

    assign sh        = {r_q, dvd_q[QB-1]};
    assign diff      = {1'b0, sh} - {2'b00, div_q};
    assign borrow    = diff[RW+1];
    assign r_nx      = borrow ? sh[RW-1:0] : RW'(diff);
    assign quo_nx    = QB'({quo_q, ~borrow});
    assign last_iter = mode_q ? (count_q == CW'(FW - 1)) : (count_q == CW'(QB - 1));
    assign int_dvd   = {f1, QB'(0)};

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        div_d    = div_q;
        r_d      = r_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        count_d  = count_q;
        q_d      = q_q;
        rem_d    = rem_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d  = mode;
                    quo_d   = '0;
                    count_d = '0;
                    if (mode) begin
                        // Integer: shift all of f1 in MSB first from a zero remainder.
                        div_d = {1'b0, f2};
                        r_d   = '0;
                        dvd_d = int_dvd[QB+FW-1 -: QB];
                    end else begin
                        // Mantissa: A>>1 < B, so the leading steps would yield zero bits;
                        // start with that prefix as the remainder and stream A[0] then zeros.
                        div_d = {1'b1, f2};
                        r_d   = {1'b1, f1[FW-1:1]};
                        dvd_d = {f1[0], {(QB-1){1'b0}}};
                    end
                    if (mode && (f2 == '0)) begin
                        state_d  = S_DONE;
                        q_d      = '1;
                        rem_d    = {1'b0, f1};
                        sticky_d = |f1;
                        dz_d     = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d     = r_nx;
                dvd_d   = dvd_q << 1;
                quo_d   = quo_nx;
                count_d = count_q + CW'(1);
                if (last_iter) begin
                    state_d  = S_DONE;
                    q_d      = quo_nx;
                    rem_d    = r_nx;
                    sticky_d = |r_nx;
                    dz_d     = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            div_q    <= '0;
            r_q      <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            count_q  <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            div_q    <= div_d;
            r_q      <= r_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            count_q  <= count_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = q_q;
    assign rem       = rem_q;
    assign sticky    = sticky_q;
    assign dz        = dz_q;

endmodule
